// File: rtl/databus_if.sv
// Versat databus request/response bundle: the master drives the request and
// write data, the slave returns ready, read data and last.
`default_nettype none

interface databus_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 2
);
  logic                  databus_valid;
  logic [ADDR_W-1:0]     databus_addr;
  logic [LEN_W-1:0]      databus_len;
  logic [DATA_W-1:0]     databus_wdata;
  logic [DATA_W/8-1:0]   databus_wstrb;
  logic                  databus_ready;
  logic [DATA_W-1:0]     databus_rdata;
  logic                  databus_last;

  modport master (
    output databus_valid, databus_addr, databus_len, databus_wdata, databus_wstrb,
    input  databus_ready, databus_rdata, databus_last
  );

  modport slave (
    input  databus_valid, databus_addr, databus_len, databus_wdata, databus_wstrb,
    output databus_ready, databus_rdata, databus_last
  );
endinterface

`default_nettype wire

// File: rtl/databus_mem_responder.sv
// ============================================================================
// databus_mem_responder: preloadable word memory answering databus bursts
// with a programmable initial latency and registered ready/last/rdata.
// Revision: 1.0
// ============================================================================
`default_nettype none

module databus_mem_responder #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int LEN_W   = 2,
  parameter int LATENCY = 1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  databus_if.slave               bus,
  input  wire logic              insertValue,
  input  wire logic [ADDR_W-1:0] addrToInsert,
  input  wire logic [DATA_W-1:0] valueToInsert
);

  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int NB_LANES = DATA_W / 8;
  localparam logic [3:0] LAT_LAST = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_BEAT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam state_t FIRST_STATE = (LATENCY > 0) ? S_WAIT : S_BEAT;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [3:0]          wait_q, wait_d;
  logic                is_wr_q, is_wr_d;
  logic                ready_q, ready_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                w_wr_beat;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      is_wr_q <= 1'b0;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      is_wr_q <= is_wr_d;
      ready_q <= ready_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    is_wr_d   = is_wr_q;
    ready_d   = 1'b0;
    last_d    = 1'b0;
    rdata_d   = rdata_q;
    w_wr_beat = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.databus_valid) begin
          addr_d  = bus.databus_addr;
          len_d   = bus.databus_len;
          is_wr_d = |bus.databus_wstrb;
          beat_d  = '0;
          wait_d  = '0;
          state_d = FIRST_STATE;
        end
      end
      S_WAIT: begin
        if (!bus.databus_valid) begin
          state_d = S_IDLE;
        end else if (wait_q == LAT_LAST) begin
          state_d = S_BEAT;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_BEAT: begin
        // Master abort: no beat is issued and no write happens on this edge.
        if (!bus.databus_valid) begin
          state_d = S_IDLE;
        end else begin
          ready_d = 1'b1;
          if (is_wr_q) begin
            w_wr_beat = 1'b1;
          end else begin
            rdata_d = mem_q[addr_q];
          end
          addr_d = addr_q + 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == len_q) begin
            last_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory is deliberately outside the reset domain; the insert is written
  // last so it overrides a same-address write beat.
  always_ff @(posedge clk) begin
    if (w_wr_beat) begin
      for (int b = 0; b < NB_LANES; b++) begin
        if (bus.databus_wstrb[b]) begin
          mem_q[addr_q][b*8 +: 8] <= bus.databus_wdata[b*8 +: 8];
        end
      end
    end
    if (insertValue) begin
      mem_q[addrToInsert] <= valueToInsert;
    end
  end

  assign bus.databus_ready = ready_q;
  assign bus.databus_last  = last_q;
  assign bus.databus_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_databus_mem_responder.sv
// Directed bench for databus_mem_responder with LATENCY=1 on a 4x8 memory.
`default_nettype none

module tb_databus_mem_responder;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          insertValue;
  logic [AW-1:0] addrToInsert;
  logic [DW-1:0] valueToInsert;
  int            n_tests = 0;
  int            n_fail  = 0;

  databus_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus ();

  databus_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .LATENCY(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .insertValue   (insertValue),
    .addrToInsert  (addrToInsert),
    .valueToInsert (valueToInsert)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] obs();
    return {bus.databus_ready, bus.databus_last, bus.databus_rdata};
  endfunction

  // Presents a request and returns just after the edge that accepts it.
  task automatic request(input logic [AW-1:0] a, input logic [LW-1:0] l,
                         input logic s, input logic [DW-1:0] wd);
    bus.databus_valid = 1'b1;
    bus.databus_addr  = a;
    bus.databus_len   = l;
    bus.databus_wstrb = s;
    bus.databus_wdata = wd;
    step();
  endtask

  task automatic finish_burst();
    bus.databus_valid = 1'b0;
    bus.databus_wstrb = '0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    insertValue = 1'b0; addrToInsert = '0; valueToInsert = '0;
    bus.databus_valid = 1'b0; bus.databus_addr = '0; bus.databus_len = '0;
    bus.databus_wdata = '0; bus.databus_wstrb = '0;
    step(); step();
    n_tests++;
    if (obs() !== 10'h000) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs(), 10'h000); end
    rst = 1'b1;
    step();
    n_tests++;
    if (obs() !== 10'h000) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", obs(), 10'h000); end
  endtask

  task automatic test_preload();
    logic [DW-1:0] vals [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      insertValue = 1'b1; addrToInsert = AW'(i); valueToInsert = vals[i];
      step();
    end
    insertValue = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    request(2'd1, 2'd0, 1'b0, 8'h00);
    n_tests++;
    if (obs() !== 10'h000) begin n_fail++; $display("FAIL single_cycN: got %h expected %h", obs(), 10'h000); end
    step();
    n_tests++;
    if (obs() !== 10'h000) begin n_fail++; $display("FAIL single_cycN1: got %h expected %h", obs(), 10'h000); end
    step();
    n_tests++;
    if (obs() !== {2'b11, 8'hFF}) begin n_fail++; $display("FAIL single_beat: got %h expected %h", obs(), {2'b11, 8'hFF}); end
    bus.databus_valid = 1'b0;
    step();
    n_tests++;
    if (obs() !== {2'b00, 8'hFF}) begin n_fail++; $display("FAIL single_done_hold: got %h expected %h", obs(), {2'b00, 8'hFF}); end
    step();
  endtask

  task automatic test_burst_read();
    logic [DW-1:0] exp_d [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [9:0] e;
    request(2'd2, 2'd3, 1'b0, 8'h00);
    step(); step();
    for (int k = 0; k < 4; k++) begin
      e = {1'b1, (k == 3), exp_d[k]};
      n_tests++;
      if (obs() !== e) begin n_fail++; $display("FAIL burst_beat%0d: got %h expected %h", k, obs(), e); end
      if (k != 3) step();
    end
    bus.databus_valid = 1'b0;
    step();
    n_tests++;
    if (obs() !== {2'b00, 8'hFF}) begin n_fail++; $display("FAIL burst_done: got %h expected %h", obs(), {2'b00, 8'hFF}); end
    step();
  endtask

  task automatic test_write_wrap();
    request(2'd3, 2'd1, 1'b1, 8'hA5);
    step(); step();
    n_tests++;
    if (obs() >> 8 !== 10'd2) begin n_fail++; $display("FAIL wr_beat0: got %h expected rdy=1 last=0", obs()); end
    bus.databus_wdata = 8'h5A;
    step();
    n_tests++;
    if (obs() >> 8 !== 10'd3) begin n_fail++; $display("FAIL wr_beat1: got %h expected rdy=1 last=1", obs()); end
    finish_burst();
    request(2'd3, 2'd1, 1'b0, 8'h00);
    step(); step();
    n_tests++;
    if (obs() !== {2'b10, 8'hA5}) begin n_fail++; $display("FAIL wrap_rd0: got %h expected %h", obs(), {2'b10, 8'hA5}); end
    step();
    n_tests++;
    if (obs() !== {2'b11, 8'h5A}) begin n_fail++; $display("FAIL wrap_rd1: got %h expected %h", obs(), {2'b11, 8'h5A}); end
    finish_burst();
  endtask

  task automatic test_insert_collision();
    request(2'd2, 2'd0, 1'b1, 8'h11);
    step();
    insertValue = 1'b1; addrToInsert = 2'd2; valueToInsert = 8'h22;
    step();
    insertValue = 1'b0;
    n_tests++;
    if (obs() >> 8 !== 10'd3) begin n_fail++; $display("FAIL coll_wr_beat: got %h expected rdy=1 last=1", obs()); end
    finish_burst();
    request(2'd1, 2'd0, 1'b0, 8'h00);
    step();
    insertValue = 1'b1; addrToInsert = 2'd1; valueToInsert = 8'h77;
    step();
    insertValue = 1'b0;
    n_tests++;
    if (obs() !== {2'b11, 8'hFF}) begin n_fail++; $display("FAIL coll_rd_old: got %h expected %h", obs(), {2'b11, 8'hFF}); end
    finish_burst();
    request(2'd1, 2'd1, 1'b0, 8'h00);
    step(); step();
    n_tests++;
    if (obs() !== {2'b10, 8'h77}) begin n_fail++; $display("FAIL coll_rd_new: got %h expected %h", obs(), {2'b10, 8'h77}); end
    step();
    n_tests++;
    if (obs() !== {2'b11, 8'h22}) begin n_fail++; $display("FAIL coll_insert_wins: got %h expected %h", obs(), {2'b11, 8'h22}); end
    finish_burst();
  endtask

  task automatic test_abort();
    request(2'd0, 2'd3, 1'b0, 8'h00);
    step(); step();
    n_tests++;
    if (obs() !== {2'b10, 8'h5A}) begin n_fail++; $display("FAIL abort_beat0: got %h expected %h", obs(), {2'b10, 8'h5A}); end
    step();
    n_tests++;
    if (obs() !== {2'b10, 8'h77}) begin n_fail++; $display("FAIL abort_beat1: got %h expected %h", obs(), {2'b10, 8'h77}); end
    bus.databus_valid = 1'b0;
    step();
    n_tests++;
    if (obs() !== {2'b00, 8'h77}) begin n_fail++; $display("FAIL abort_stop: got %h expected %h", obs(), {2'b00, 8'h77}); end
    step();
    n_tests++;
    if (obs() !== {2'b00, 8'h77}) begin n_fail++; $display("FAIL abort_quiet: got %h expected %h", obs(), {2'b00, 8'h77}); end
    request(2'd2, 2'd0, 1'b0, 8'h00);
    step(); step();
    n_tests++;
    if (obs() !== {2'b11, 8'h22}) begin n_fail++; $display("FAIL abort_next_req: got %h expected %h", obs(), {2'b11, 8'h22}); end
    finish_burst();
  endtask

  task automatic test_reset_midburst();
    logic [DW-1:0] exp_d [4] = '{8'h5A, 8'h77, 8'h22, 8'hA5};
    logic [9:0] e;
    request(2'd0, 2'd3, 1'b0, 8'h00);
    step(); step();
    n_tests++;
    if (obs() !== {2'b10, 8'h5A}) begin n_fail++; $display("FAIL rstmid_beat0: got %h expected %h", obs(), {2'b10, 8'h5A}); end
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (obs() !== 10'h000) begin n_fail++; $display("FAIL rstmid_async: got %h expected %h", obs(), 10'h000); end
    bus.databus_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    n_tests++;
    if (obs() !== 10'h000) begin n_fail++; $display("FAIL rstmid_idle: got %h expected %h", obs(), 10'h000); end
    step();
    request(2'd0, 2'd3, 1'b0, 8'h00);
    step(); step();
    for (int k = 0; k < 4; k++) begin
      e = {1'b1, (k == 3), exp_d[k]};
      n_tests++;
      if (obs() !== e) begin n_fail++; $display("FAIL rstmid_retain%0d: got %h expected %h", k, obs(), e); end
      if (k != 3) step();
    end
    finish_burst();
  endtask

  initial begin
    test_reset();
    test_preload();
    test_single_read();
    test_burst_read();
    test_write_wrap();
    test_insert_collision();
    test_abort();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
